// File: rtl/t9990_blit_xy_if.sv
// Command/coordinate bundle between a blitter sequencer and the XY rectangle walker.
// The slave side is the walker; the master side issues commands and consumes pixels.
interface t9990_blit_xy_if;
  logic        start;
  logic        stop;
  logic [10:0] dx;
  logic [11:0] dy;
  logic [10:0] nx;
  logic [11:0] ny;
  logic        dix;
  logic        diy;
  logic [1:0]  ximm;
  logic        p1;
  logic [10:0] x;
  logic [11:0] y;
  logic        valid;
  logic        ack;
  logic        eol;
  logic        last;
  logic        busy;
  logic        done;

  modport master (
    output start, stop, dx, dy, nx, ny, dix, diy, ximm, p1, ack,
    input  x, y, valid, eol, last, busy, done
  );

  modport slave (
    input  start, stop, dx, dy, nx, ny, dix, diy, ximm, p1, ack,
    output x, y, valid, eol, last, busy, done
  );
endinterface

// File: rtl/t9990_blit_xy.sv
// Rectangle walker: emits one X/Y coordinate per accepted handshake, row by row,
// with X wrapped to the selected image width and Y wrapped to 12 bits.
module t9990_blit_xy (
  input  logic            i_clk,
  input  logic            i_rst,
  t9990_blit_xy_if.slave  bus
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state;
  logic [10:0] r_dx, w_dx;
  logic [10:0] r_mask, w_mask;
  logic [10:0] r_x, w_x;
  logic [11:0] r_y, w_y;
  logic [11:0] r_nx, w_nx;
  logic [11:0] r_col, w_col;
  logic [12:0] r_row, w_row;
  logic        r_dix, w_dix;
  logic        r_diy, w_diy;
  logic        r_done, w_done;

  logic [10:0] w_in_mask;
  logic [10:0] w_x_step;
  logic [11:0] w_y_step;
  logic        w_run;
  logic        w_eol;
  logic        w_last;

  // Width mask from XIMM (256/512/1024/2048); P1 forces the 1024-wide mask.
  genvar gi;
  generate
    for (gi = 0; gi < 11; gi = gi + 1) begin : g_mask
      if (gi < 8) begin : g_low
        assign w_in_mask[gi] = 1'b1;
      end else if (gi == 8) begin : g_b8
        assign w_in_mask[gi] = bus.p1 | (bus.ximm != 2'd0);
      end else if (gi == 9) begin : g_b9
        assign w_in_mask[gi] = bus.p1 | bus.ximm[1];
      end else begin : g_b10
        assign w_in_mask[gi] = ~bus.p1 & (bus.ximm == 2'd3);
      end
    end
  endgenerate

  assign w_run    = (r_state == S_RUN);
  assign w_eol    = w_run && (r_col == 12'd1);
  assign w_last   = w_eol && (r_row == 13'd1);
  assign w_x_step = (r_dix ? (r_x - 11'd1) : (r_x + 11'd1)) & r_mask;
  assign w_y_step = r_diy ? (r_y - 12'd1) : (r_y + 12'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_dx    <= '0;
      r_mask  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_nx    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_dix   <= 1'b0;
      r_diy   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_dx    <= w_dx;
      r_mask  <= w_mask;
      r_x     <= w_x;
      r_y     <= w_y;
      r_nx    <= w_nx;
      r_col   <= w_col;
      r_row   <= w_row;
      r_dix   <= w_dix;
      r_diy   <= w_diy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_dx    = r_dx;
    w_mask  = r_mask;
    w_x     = r_x;
    w_y     = r_y;
    w_nx    = r_nx;
    w_col   = r_col;
    w_row   = r_row;
    w_dix   = r_dix;
    w_diy   = r_diy;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state = S_RUN;
          w_mask  = w_in_mask;
          w_dx    = bus.dx & w_in_mask;
          w_x     = bus.dx & w_in_mask;
          w_y     = bus.dy;
          w_dix   = bus.dix;
          w_diy   = bus.diy;
          w_nx    = (bus.nx == 11'd0) ? 12'd2048 : {1'b0, bus.nx};
          w_col   = (bus.nx == 11'd0) ? 12'd2048 : {1'b0, bus.nx};
          w_row   = (bus.ny == 12'd0) ? 13'd4096 : {1'b0, bus.ny};
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state = S_IDLE;
          w_col   = '0;
          w_row   = '0;
        end else if (bus.ack) begin
          if (w_last) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_col   = '0;
            w_row   = '0;
          end else if (w_eol) begin
            w_x   = r_dx;
            w_y   = w_y_step;
            w_col = r_nx;
            w_row = r_row - 13'd1;
          end else begin
            w_x   = w_x_step;
            w_col = r_col - 12'd1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.x     = r_x;
  assign bus.y     = r_y;
  assign bus.valid = w_run;
  assign bus.busy  = w_run;
  assign bus.eol   = w_eol;
  assign bus.last  = w_last;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_t9990_blit_xy.sv
// Scoreboard bench for the XY rectangle walker: expected pixels are queued at START
// and popped by a negedge monitor on every accepted transfer.
module tb_t9990_blit_xy;
  typedef struct packed {
    logic [10:0] x;
    logic [11:0] y;
    logic        eol;
    logic        last;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  t9990_blit_xy_if bus ();

  t9990_blit_xy dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  px_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;
  int  done_cnt = 0;
  int  valid_cycles = 0;
  int  xfer_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference pixel order, computed directly from row/column indices.
  task automatic push_rect(input int dx, input int dy, input int nx, input int ny,
                           input bit dix, input bit diy, input int ximm, input bit p1);
    int cols, rows, width, xv, yv;
    px_t e;
    cols  = (nx == 0) ? 2048 : nx;
    rows  = (ny == 0) ? 4096 : ny;
    width = p1 ? 1024 : (256 << ximm);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        xv = dix ? (dx - c) : (dx + c);
        xv = ((xv % width) + width) % width;
        yv = diy ? (dy - r) : (dy + r);
        yv = ((yv % 4096) + 4096) % 4096;
        e.x    = 11'(xv);
        e.y    = 12'(yv);
        e.eol  = (c == cols - 1);
        e.last = (c == cols - 1) && (r == rows - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops on each transfer, checks stall
  // stability and that DONE follows exactly the LAST transfer.
  initial begin
    px_t e, hold;
    logic hold_flag, exp_done;
    hold_flag = 1'b0;
    exp_done  = 1'b0;
    hold      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_flag = 1'b0;
        exp_done  = 1'b0;
      end else begin
        check("done_pulse", bus.done, exp_done);
        if (bus.done) done_cnt++;
        exp_done = 1'b0;
        if (bus.valid) valid_cycles++;
        if (hold_flag && bus.valid) begin
          check("stall_x", bus.x, hold.x);
          check("stall_y", bus.y, hold.y);
          check("stall_eol", bus.eol, hold.eol);
          check("stall_last", bus.last, hold.last);
        end
        hold_flag = 1'b0;
        if (bus.valid && bus.ack && !bus.stop) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("x", bus.x, e.x);
            check("y", bus.y, e.y);
            check("eol", bus.eol, e.eol);
            check("last", bus.last, e.last);
            exp_done = e.last;
          end
        end else if (bus.valid && !bus.stop) begin
          hold.x    = bus.x;
          hold.y    = bus.y;
          hold.eol  = bus.eol;
          hold.last = bus.last;
          hold_flag = 1'b1;
        end
      end
    end
  end

  task automatic do_start(input int dx, input int dy, input int nx, input int ny,
                          input bit dix, input bit diy, input int ximm, input bit p1);
    push_rect(dx, dy, nx, ny, dix, diy, ximm, p1);
    @(posedge clk); #1;
    bus.dx    = 11'(dx);
    bus.dy    = 12'(dy);
    bus.nx    = 11'(nx);
    bus.ny    = 12'(ny);
    bus.dix   = dix;
    bus.diy   = diy;
    bus.ximm  = 2'(ximm);
    bus.p1    = p1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_rect(input int dx, input int dy, input int nx, input int ny,
                          input bit dix, input bit diy, input int ximm, input bit p1,
                          input bit rnd_ack, input bit inj_start);
    int  done_base, vc_base, xf_base, npix, budget;
    bit  fin;
    npix      = ((nx == 0) ? 2048 : nx) * ((ny == 0) ? 4096 : ny);
    budget    = npix * 4 + 20;
    done_base = done_cnt;
    vc_base   = valid_cycles;
    xf_base   = xfer_cnt;
    do_start(dx, dy, nx, ny, dix, diy, ximm, p1);
    check("lat_valid", bus.valid, 1);
    check("lat_busy", bus.busy, 1);
    fin = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      bus.ack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj_start && cyc == 100) begin
        bus.start = 1'b1;
        bus.dx    = 11'd7;
        bus.dy    = 12'd99;
        bus.nx    = 11'd3;
        bus.dix   = ~dix;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      fin = !bus.busy;
    end
    bus.start = 1'b0;
    bus.ack   = 1'b1;
    if (!fin) check("walk_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt - done_base, 1);
    check("xfer_count", xfer_cnt - xf_base, npix);
    check("queue_empty", exp_q.size(), 0);
    check("idle_valid", bus.valid, 0);
    check("idle_busy", bus.busy, 0);
    if (!rnd_ack) check("valid_cycles", valid_cycles - vc_base, npix);
    $display("rect dx=%0d dy=%0d nx=%0d ny=%0d dix=%0d diy=%0d ximm=%0d p1=%0d rnd=%0d done",
             dx, dy, nx, ny, dix, diy, ximm, p1, rnd_ack);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_eol"}, bus.eol, 0);
    check({tag, "_last"}, bus.last, 0);
    check({tag, "_x"}, bus.x, 0);
    check({tag, "_y"}, bus.y, 0);
  endtask

  initial begin
    int done_base;
    bus.start = 1'b0; bus.stop = 1'b0; bus.ack = 1'b1;
    bus.dx = '0; bus.dy = '0; bus.nx = '0; bus.ny = '0;
    bus.dix = 1'b0; bus.diy = 1'b0; bus.ximm = 2'd3; bus.p1 = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset released");

    run_rect(10, 5, 3, 2, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    run_rect(254, 0, 4, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_rect(1, 0, 4, 1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_rect(3, 0, 1, 2, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run_rect(1023, 20, 2, 1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    run_rect(500, 4094, 3, 4, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    run_rect(100, 200, 4, 3, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0);

    // START together with STOP in IDLE must not begin a walk.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_busy", bus.busy, 0);
    $display("start+stop in idle");

    // STOP after two transfers, with ACK high in the STOP cycle.
    done_base = done_cnt;
    do_start(10, 10, 4, 3, 1'b0, 1'b0, 3, 1'b0);
    bus.ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stop_q_after2", exp_q.size(), 10);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("stop_valid", bus.valid, 0);
    check("stop_busy", bus.busy, 0);
    check("stop_q_unchanged", exp_q.size(), 10);
    repeat (2) @(posedge clk);
    #1;
    check("stop_no_done", done_cnt - done_base, 0);
    exp_q.delete();
    $display("stop mid-walk");

    // Asynchronous reset in the middle of a walk.
    done_base = done_cnt;
    do_start(30, 40, 4, 3, 1'b0, 1'b0, 3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_no_done", done_cnt - done_base, 0);
    $display("reset mid-walk");
    run_rect(7, 8, 2, 2, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);

    run_rect(5, 9, 0, 1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
